// File: rtl/motor_move_ctrl.sv
// motor_move_ctrl
//   Move sequencer that sits in front of the 3-phase stepper pulse distributor.
//   It takes one move command at a time and emits single-cycle step strobes.
//   The gap between strobes follows a linear accel / cruise / decel period
//   profile. The direction level is held steady for the whole move.
//
// Ports
//   CP          in   clock, everything on the rising edge
//   CR          in   synchronous active-high reset
//   cmd_valid   in   move command present
//   cmd_ready   out  high only when idle; accept on cmd_valid && cmd_ready
//   cmd_dir     in   direction for the move
//   cmd_steps   in   number of step strobes to emit
//   cmd_period  in   cruise period in CP cycles
//   abort       in   stop the current move immediately
//   M           out  direction level to the distributor
//   step        out  one-cycle step strobe to the distributor
//   busy        out  move in progress
//   done        out  one-cycle move-complete pulse
//   steps_left  out  steps still to emit
module motor_move_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DIV_W        = 16,
  parameter int START_PERIOD = 20,
  parameter int RAMP_STEP    = 4
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_period,
  input  logic             abort,
  output logic             M,
  output logic             step,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_left
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEL  = 2'd1,
    S_CRUISE = 2'd2,
    S_DECEL  = 2'd3
  } state_t;

  // Period arithmetic is done one bit wider so ramping up never wraps.
  localparam logic [DIV_W:0]   START_W = (DIV_W+1)'(START_PERIOD);
  localparam logic [DIV_W:0]   RAMP_W  = (DIV_W+1)'(RAMP_STEP);
  localparam logic [DIV_W-1:0] START_N = DIV_W'(START_PERIOD);
  localparam logic [DIV_W-1:0] RAMP_N  = DIV_W'(RAMP_STEP);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_TWO = DIV_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic [DIV_W-1:0] cruise_q, cruise_d;
  logic [DIV_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] accel_q, accel_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             m_q, m_d;
  logic             step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  // fin_q: move finished, done/busy/ready update on the following edge
  logic             fin_q, fin_d;

  logic             accept_s, active_s, abort_s, fire_s, to_decel_s;
  logic [CNT_W-1:0] left_dec_s;
  logic [DIV_W-1:0] cruise_in_s, per_in_s, per_dn_s, per_upc_s;
  logic [DIV_W:0]   per_up_s, dn_lim_s;

  assign accept_s    = ready_q & cmd_valid;
  assign active_s    = (state_q != S_IDLE);
  assign abort_s     = active_s & abort;
  // The strobe fires on the edge where the reload-to-zero timer expires.
  assign fire_s      = active_s & ~abort & (timer_q == {DIV_W{1'b0}});
  assign left_dec_s  = left_q - CNT_ONE;
  // Deceleration starts once the remaining steps fit the steps spent ramping up.
  assign to_decel_s  = (state_q != S_DECEL) & (left_dec_s <= accel_q);
  assign cruise_in_s = (cmd_period < DIV_TWO) ? DIV_TWO : cmd_period;
  assign per_in_s    = ({1'b0, cruise_in_s} > START_W) ? cruise_in_s : START_N;
  assign per_up_s    = {1'b0, per_q} + RAMP_W;
  assign per_upc_s   = (per_up_s > START_W) ? START_N : per_up_s[DIV_W-1:0];
  assign dn_lim_s    = {1'b0, cruise_q} + RAMP_W;
  assign per_dn_s    = ({1'b0, per_q} >= dn_lim_s) ? (per_q - RAMP_N) : cruise_q;

  // State and datapath registers with synchronous reset
  always_ff @(posedge CP) begin
    if (CR) begin
      state_q  <= S_IDLE;
      per_q    <= {DIV_W{1'b0}};
      cruise_q <= {DIV_W{1'b0}};
      timer_q  <= {DIV_W{1'b0}};
      accel_q  <= {CNT_W{1'b0}};
      left_q   <= {CNT_W{1'b0}};
      m_q      <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      cruise_q <= cruise_d;
      timer_q  <= timer_d;
      accel_q  <= accel_d;
      left_q   <= left_d;
      m_q      <= m_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      fin_q    <= fin_d;
    end
  end

  // Next-state logic for the move profile FSM
  always_comb begin
    state_d = state_q;
    if (accept_s) begin
      if (cmd_steps == {CNT_W{1'b0}}) begin
        state_d = S_IDLE;
      end else if (per_in_s == cruise_in_s) begin
        state_d = S_CRUISE;
      end else begin
        state_d = S_ACCEL;
      end
    end else if (abort_s) begin
      state_d = S_IDLE;
    end else if (fire_s) begin
      if (left_dec_s == {CNT_W{1'b0}}) begin
        state_d = S_IDLE;
      end else if (to_decel_s) begin
        state_d = S_DECEL;
      end else if ((state_q == S_ACCEL) && (per_dn_s == cruise_q)) begin
        state_d = S_CRUISE;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    per_d    = per_q;
    cruise_d = cruise_q;
    timer_d  = timer_q;
    accel_d  = accel_q;
    left_d   = left_q;
    m_d      = m_q;
    step_d   = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    fin_d    = 1'b0;
    if (fin_q) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      ready_d = 1'b1;
    end else if (accept_s) begin
      m_d      = cmd_dir;
      left_d   = cmd_steps;
      accel_d  = {CNT_W{1'b0}};
      cruise_d = cruise_in_s;
      per_d    = per_in_s;
      timer_d  = per_in_s - DIV_ONE;
      busy_d   = 1'b1;
      ready_d  = 1'b0;
      fin_d    = (cmd_steps == {CNT_W{1'b0}});
    end else if (abort_s) begin
      // steps_left is frozen; the pending strobe is dropped
      done_d  = 1'b1;
      busy_d  = 1'b0;
      ready_d = 1'b1;
      timer_d = {DIV_W{1'b0}};
    end else if (fire_s) begin
      step_d = 1'b1;
      left_d = left_dec_s;
      if (left_dec_s == {CNT_W{1'b0}}) begin
        fin_d = 1'b1;
      end else if (to_decel_s) begin
        per_d = per_upc_s;
      end else if (state_q == S_ACCEL) begin
        per_d   = per_dn_s;
        accel_d = (accel_q == {CNT_W{1'b1}}) ? accel_q : (accel_q + CNT_ONE);
      end else if (state_q == S_DECEL) begin
        per_d = per_upc_s;
      end else begin
        per_d = per_q;
      end
      timer_d = per_d - DIV_ONE;
    end else if (active_s) begin
      timer_d = timer_q - DIV_ONE;
    end else begin
      timer_d = timer_q;
    end
  end

  assign cmd_ready  = ready_q;
  assign M          = m_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign steps_left = left_q;

endmodule

// File: tb/tb_motor_move_ctrl.sv
// tb_motor_move_ctrl
//   Scoreboard bench for motor_move_ctrl. Each command pushes its expected
//   strobe/done events (cycle, steps_left, M) into a queue. A monitor on the
//   falling edge pops one entry per strobe or done pulse and compares it.
module tb_motor_move_ctrl;

  logic        CP, CR, cmd_valid, cmd_ready, cmd_dir, abort;
  logic [15:0] cmd_steps, cmd_period, steps_left;
  logic        M, step, busy, done;

  motor_move_ctrl #(.CNT_W(16), .DIV_W(16), .START_PERIOD(20), .RAMP_STEP(4)) dut (
    .CP(CP), .CR(CR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .abort(abort), .M(M), .step(step), .busy(busy), .done(done),
    .steps_left(steps_left)
  );

  typedef struct {
    logic is_done;
    int   cyc;
    int   left;
    logic m;
  } ev_t;

  ev_t exp_q[$];
  int  ivq[$];
  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  always @(posedge CP) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: every strobe or done pulse consumes one expected event
  always @(negedge CP) begin
    if (!CR && (step || done)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, step, done}, 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_kind", {30'd0, step, done}, e.is_done ? 32'd1 : 32'd2);
        chk(e.is_done ? "done_cycle" : "step_cycle", cyc, e.cyc);
        chk(e.is_done ? "done_left" : "step_left", 32'(steps_left), e.left);
        chk("M_level", 32'(M), 32'(e.m));
        if (e.is_done) begin
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_ready", 32'(cmd_ready), 32'd1);
        end else begin
          chk("step_busy", 32'(busy), 32'd1);
        end
      end
    end
  end

  task automatic send(input logic dir, input int steps, input int period, output int t0);
    @(posedge CP); #1;
    chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = 16'(steps);
    cmd_period = 16'(period);
    t0 = cyc + 1;
    @(posedge CP); #1;
    cmd_valid = 1'b0;
  endtask

  // Push n_push strobes using ivq intervals, optionally followed by done
  task automatic push_move(input logic dir, input int steps, input int t0,
                           input int n_push, input bit with_done);
    int t;
    ev_t e;
    t = t0;
    for (int k = 0; k < n_push; k++) begin
      t = t + ivq[k];
      e.is_done = 1'b0; e.cyc = t; e.left = steps - k - 1; e.m = dir;
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1; e.cyc = t + 1; e.left = 0; e.m = dir;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_size(input int n, input int budget);
    for (int i = 0; i < budget && exp_q.size() > n; i++) @(posedge CP);
    if (exp_q.size() > n) begin
      chk("event_timeout", exp_q.size(), n);
      while (exp_q.size() > n) void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int t0;
    ev_t e;
    CR = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
    cmd_steps = 16'd0; cmd_period = 16'd0;

    // 1. reset
    repeat (2) @(posedge CP);
    #1 CR = 1'b0;
    chk("rst_M", 32'(M), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_left", 32'(steps_left), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);

    // 2. full profile
    ivq = '{20, 16, 12, 12, 12, 12, 12, 12, 16, 20};
    send(1'b1, 10, 12, t0);
    push_move(1'b1, 10, t0, 10, 1'b1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(cmd_ready), 32'd0);
    wait_size(0, 400);

    // 3. decel begins during accel
    ivq = '{20, 16, 20};
    send(1'b0, 3, 8, t0);
    push_move(1'b0, 3, t0, 3, 1'b1);
    wait_size(0, 200);

    // 4. zero-step move then slow cruise-only move
    ivq = '{};
    send(1'b1, 0, 5, t0);
    push_move(1'b1, 0, t0, 0, 1'b1);
    wait_size(0, 20);
    ivq = '{30, 30};
    send(1'b1, 2, 30, t0);
    push_move(1'b1, 2, t0, 2, 1'b1);
    wait_size(0, 200);

    // 5. abort after the 4th strobe
    ivq = '{20, 16, 12, 12};
    send(1'b0, 10, 12, t0);
    push_move(1'b0, 10, t0, 4, 1'b0);
    wait_size(0, 200);
    #1 abort = 1'b1;
    e.is_done = 1'b1; e.cyc = cyc + 1; e.left = 6; e.m = 1'b0;
    exp_q.push_back(e);
    @(posedge CP); #1 abort = 1'b0;
    repeat (40) @(posedge CP);
    wait_size(0, 10);
    chk("abort_left_hold", 32'(steps_left), 32'd6);
    ivq = '{30, 30};
    send(1'b1, 2, 30, t0);
    push_move(1'b1, 2, t0, 2, 1'b1);
    wait_size(0, 200);

    // 6. reset mid-cruise with cmd_valid held during busy
    ivq = '{20, 16, 12, 12};
    send(1'b1, 10, 12, t0);
    push_move(1'b1, 10, t0, 4, 1'b0);
    wait_size(1, 200);
    #1;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 16'd5; cmd_period = 16'd12;
    wait_size(0, 40);
    @(posedge CP); #1;
    chk("busy_cmd_ignored_M", 32'(M), 32'd1);
    chk("busy_cmd_ignored_left", 32'(steps_left), 32'd6);
    CR = 1'b1; cmd_valid = 1'b0;
    @(posedge CP); #1 CR = 1'b0;
    chk("midrst_step", 32'(step), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_M", 32'(M), 32'd0);
    chk("midrst_left", 32'(steps_left), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd1);
    repeat (60) @(posedge CP);
    chk("post_rst_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
